// File: rtl/dspengine_buffer_pkg.sv
// Shared definitions for the single-packet DSP engine buffer: state codes,
// VITA flag bit positions and the 36-bit word type.
package dspengine_buffer_pkg;

    localparam int unsigned DATA_W  = 36;
    localparam int unsigned SOF_BIT = 32;
    localparam int unsigned EOF_BIT = 33;

    typedef logic [DATA_W-1:0] word_t;

    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_HDR    = 2'd2;
    localparam logic [1:0] ST_SEND   = 2'd3;

endpackage

// File: rtl/dspengine_buffer_if.sv
// FIFO36 stream bundle: upstream input and downstream output handshakes.
interface dspengine_buffer_if import dspengine_buffer_pkg::*;;

    word_t data_i;
    logic  src_rdy_i;
    logic  dst_rdy_o;
    word_t data_o;
    logic  src_rdy_o;
    logic  dst_rdy_i;

    modport slave (
        input  data_i, src_rdy_i, dst_rdy_i,
        output dst_rdy_o, data_o, src_rdy_o
    );

    modport master (
        output data_i, src_rdy_i, dst_rdy_i,
        input  dst_rdy_o, data_o, src_rdy_o
    );

endinterface

// File: rtl/dspengine_buffer_ram_2port.sv
// Dual-port block RAM, synchronous read with one cycle of latency on each port.
// Port A reads and writes, port B only reads.
module ram_2port #(
    parameter int DWIDTH = 36,
    parameter int AWIDTH = 9
) (
    input  logic              clka,
    input  logic              ena,
    input  logic              wea,
    input  logic [AWIDTH-1:0] addra,
    input  logic [DWIDTH-1:0] dia,
    output logic [DWIDTH-1:0] doa,
    input  logic              clkb,
    input  logic              enb,
    input  logic [AWIDTH-1:0] addrb,
    output logic [DWIDTH-1:0] dob
);

    logic [DWIDTH-1:0] r_mem [0:(2**AWIDTH)-1];

    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) begin
                r_mem[addra] <= dia;
            end
            doa <= r_mem[addra];
        end
    end

    always_ff @(posedge clkb) begin
        if (enb) begin
            dob <= r_mem[addrb];
        end
    end

endmodule

// File: rtl/dspengine_buffer.sv
// Captures one VITA packet into RAM, hands the RAM to an in-place DSP engine,
// then streams the packet out using the length the engine left in the header.
module dspengine_buffer import dspengine_buffer_pkg::*; #(
    parameter int BUF_SIZE = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    dspengine_buffer_if.slave   strm,
    output logic                access_ok,
    output logic [BUF_SIZE-1:0] access_len,
    input  logic [BUF_SIZE-1:0] access_adr,
    input  logic                access_we,
    input  logic                access_stb,
    input  word_t               access_dat_i,
    output word_t               access_dat_o,
    input  logic                access_done,
    input  logic                access_skip_read
);

    localparam logic [BUF_SIZE-1:0] LAST_ADR = '1;
    localparam logic [BUF_SIZE:0]   MAX_LEN  = {1'b1, {BUF_SIZE{1'b0}}};
    localparam logic [BUF_SIZE:0]   LEN_ONE  = {{BUF_SIZE{1'b0}}, 1'b1};

    logic [1:0]          r_state;
    logic [BUF_SIZE-1:0] r_fill_adr;
    logic [BUF_SIZE-1:0] r_access_len;
    logic                r_drop;
    logic                r_hdr_phase;
    logic [BUF_SIZE:0]   r_out_len;
    logic [BUF_SIZE:0]   r_rd_idx;
    logic                r_rd_vld;
    word_t               r_data_o;
    logic                r_src_rdy_o;
    logic                r_out_last;

    logic                w_fill;
    logic                w_accept;
    logic                w_sof;
    logic                w_eof;
    logic [BUF_SIZE-1:0] w_fill_wadr;
    logic                w_fill_we;
    logic [BUF_SIZE-1:0] w_addra;
    logic                w_wea;
    word_t               w_dia;
    word_t               w_doa;
    logic [BUF_SIZE-1:0] w_addrb;
    word_t               w_dob;
    logic [BUF_SIZE:0]   w_hdr_len;
    logic                w_out_take;
    logic                w_load;
    logic [BUF_SIZE:0]   w_next_idx;
    logic [BUF_SIZE:0]   w_src_idx;
    logic [BUF_SIZE:0]   w_src_len;
    logic                w_is_last;
    word_t               w_out_word;
    logic                w_unused;

    assign w_fill      = (r_state == ST_FILL);
    assign w_accept    = w_fill & strm.src_rdy_i;
    assign w_sof       = strm.data_i[SOF_BIT];
    assign w_eof       = strm.data_i[EOF_BIT];
    assign w_fill_wadr = w_sof ? '0 : r_fill_adr;
    assign w_fill_we   = w_accept & ~r_drop;

    always_comb begin
        w_addra = access_adr;
        w_wea   = 1'b0;
        w_dia   = access_dat_i;
        if (w_fill) begin
            w_addra = w_fill_wadr;
            w_wea   = w_fill_we;
            w_dia   = strm.data_i;
        end else if (r_state == ST_ACCESS) begin
            w_wea = access_we & access_stb;
        end
    end

    ram_2port #(
        .DWIDTH (DATA_W),
        .AWIDTH (BUF_SIZE)
    ) u_ram (
        .clka  (clk),
        .ena   (1'b1),
        .wea   (w_wea),
        .addra (w_addra),
        .dia   (w_dia),
        .doa   (w_doa),
        .clkb  (clk),
        .enb   (1'b1),
        .addrb (w_addrb),
        .dob   (w_dob)
    );

    always_comb begin
        w_hdr_len = (BUF_SIZE+1)'(w_dob[15:0]);
        if (w_dob[15:0] == 16'd0) begin
            w_hdr_len = LEN_ONE;
        end else if (32'(w_dob[15:0]) > 32'(MAX_LEN)) begin
            w_hdr_len = MAX_LEN;
        end
    end

    // Port B re-reads the word on dob while the output register is stalled,
    // so dob always holds the next word to load and no skid buffer is needed.
    assign w_out_take = r_src_rdy_o & strm.dst_rdy_i;
    assign w_load     = (r_state == ST_SEND) & r_rd_vld & (~r_src_rdy_o | strm.dst_rdy_i);
    assign w_next_idx = w_load ? r_rd_idx + LEN_ONE : r_rd_idx;

    always_comb begin
        w_addrb = w_next_idx[BUF_SIZE-1:0];
        if (r_state == ST_HDR) begin
            w_addrb = r_hdr_phase ? BUF_SIZE'(1) : '0;
        end
    end

    always_comb begin
        w_src_idx = r_rd_idx;
        w_src_len = r_out_len;
        if (r_state == ST_HDR) begin
            w_src_idx = '0;
            w_src_len = w_hdr_len;
        end
        w_is_last  = (w_src_idx == w_src_len - LEN_ONE);
        w_out_word = {2'b00,
                      w_dob[EOF_BIT] | w_is_last,
                      w_dob[SOF_BIT] | (w_src_idx == '0),
                      w_dob[31:0]};
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_state      <= ST_FILL;
            r_fill_adr   <= '0;
            r_access_len <= '0;
            r_drop       <= 1'b0;
            r_hdr_phase  <= 1'b0;
            r_out_len    <= '0;
            r_rd_idx     <= '0;
            r_rd_vld     <= 1'b0;
            r_data_o     <= '0;
            r_src_rdy_o  <= 1'b0;
            r_out_last   <= 1'b0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_accept) begin
                        if (r_drop) begin
                            if (w_eof) begin
                                r_drop     <= 1'b0;
                                r_fill_adr <= '0;
                            end
                        end else if (w_eof) begin
                            r_access_len <= w_fill_wadr + 1'b1;
                            r_fill_adr   <= '0;
                            r_state      <= ST_ACCESS;
                        end else if (w_fill_wadr == LAST_ADR) begin
                            r_drop     <= 1'b1;
                            r_fill_adr <= '0;
                        end else begin
                            r_fill_adr <= w_fill_wadr + 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (access_done) begin
                        r_state     <= access_skip_read ? ST_FILL : ST_HDR;
                        r_hdr_phase <= 1'b0;
                    end
                end
                ST_HDR: begin
                    if (!r_hdr_phase) begin
                        r_hdr_phase <= 1'b1;
                    end else begin
                        // dob holds word 0 now: it doubles as the first prefetch.
                        r_out_len   <= w_hdr_len;
                        r_data_o    <= w_out_word;
                        r_src_rdy_o <= 1'b1;
                        r_out_last  <= w_is_last;
                        r_rd_idx    <= LEN_ONE;
                        r_rd_vld    <= (w_hdr_len > LEN_ONE);
                        r_state     <= ST_SEND;
                    end
                end
                default: begin
                    if (w_load) begin
                        r_data_o    <= w_out_word;
                        r_src_rdy_o <= 1'b1;
                        r_out_last  <= w_is_last;
                    end else if (w_out_take) begin
                        r_src_rdy_o <= 1'b0;
                    end
                    r_rd_idx <= w_next_idx;
                    r_rd_vld <= (w_next_idx < r_out_len);
                    if (w_out_take && r_out_last) begin
                        r_state <= ST_FILL;
                    end
                end
            endcase
        end
    end

    assign strm.dst_rdy_o = w_fill;
    assign strm.data_o    = r_data_o;
    assign strm.src_rdy_o = r_src_rdy_o;
    assign access_ok      = (r_state == ST_ACCESS);
    assign access_len     = r_access_len;
    assign access_dat_o   = w_doa;
    assign w_unused       = ^w_dob[35:34];

endmodule

// File: doc/dspengine_buffer.md
# dspengine_buffer

Single-packet buffer and access host for the in-place DSP engines on the 36-bit VITA packet path. It captures one packet from an upstream FIFO36 stream into block RAM and grants RAM access to one engine such as the 16-to-8 converter. When the engine signals completion, it streams the modified packet downstream using the length the engine wrote into the header word.

## Interface
- BUF_SIZE, 9: RAM address width; capacity is 2^BUF_SIZE words of 36 bits.
- clk  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-high.
- clear  in  1  synchronous flush; same effect as reset except engine settings.
- data_i  in  36  input word: [31:0] payload, [32] SOF, [33] EOF, [35:34] ignored.
- src_rdy_i / dst_rdy_o  in / out  1 / 1  input handshake.
- data_o  out  36  output word, same format; [35:34] driven 0.
- src_rdy_o / dst_rdy_i  out / in  1 / 1  output handshake.
- access_ok  out  1  packet resident; engine owns RAM.
- access_len  out  BUF_SIZE  words stored, including header.
- access_adr  in  BUF_SIZE  engine address.
- access_we / access_stb  in  1 / 1  engine write enable / access strobe.
- access_dat_i  in  36  engine write data.
- access_dat_o  out  36  RAM read data; one cycle after address.
- access_done  in  1  engine finished, one-cycle pulse.
- access_skip_read  in  1  sampled with access_done; 1 = discard packet.

## Operation
- FILL: dst_rdy_o=1.
  - Each accepted word is written at fill_adr, then fill_adr increments.
  - A word with SOF while fill_adr≠0 restarts at address 0, written at 0.
  - On an accepted EOF word: access_len←fill_adr+1, go to ACCESS.
  - Overflow: an accepted non-EOF word at fill_adr=2^BUF_SIZE−1 sets the drop flag. Remaining words to EOF are accepted and discarded, then the block returns to FILL with fill_adr=0. access_ok is never raised for that packet.
- ACCESS: access_ok=1, dst_rdy_o=0.
  - RAM read address = access_adr.
  - Write when access_we&access_stb.
  - On access_done: if access_skip_read, go to FILL; else go to HDR.
- HDR: read address 0; latch out_len←header[15:0] from RAM data on the next cycle.
  - out_len=0 is treated as 1.
  - out_len>2^BUF_SIZE is clamped to 2^BUF_SIZE.
  - Go to SEND.
- SEND: streams words 0..out_len−1.
  - data_o[32] is forced to 1 on word 0; data_o[33] is forced to 1 on word out_len−1.
  - Stored flag bits are otherwise passed through.
  - After the last word is accepted, return to FILL with fill_adr=0.
- Output path: one-entry prefetch register so src_rdy_o can stay high every cycle while dst_rdy_i=1. No bubbles after the first word.
- Reset/clear in any state: state←FILL, fill_adr←0, drop←0, access_ok←0, access_len←0, src_rdy_o←0, dst_rdy_o←1 from the next cycle. A partial packet is lost.

## Timing
- RAM: synchronous read, 1-cycle latency on both the fill/engine port and the output port.
- access_ok rises the cycle after the EOF word is accepted.
- The engine may present address 0 in its first access_ok cycle. Data appears on access_dat_o the following cycle.
- First src_rdy_o: 3 cycles after access_done (HDR read, header latch, prefetch). Subsequent words: 1 per cycle under dst_rdy_i=1.
- dst_rdy_i low: data_o and src_rdy_o hold stable until accepted.
- Minimum turnaround: dst_rdy_o rises the cycle after the final output word is accepted.
- access_done outside ACCESS is ignored.

## Structure
- Shared package: state encodings (FILL, ACCESS, HDR, SEND) and flag bit positions SOF=32, EOF=33.
- Sub-module: ram_2port (existing), width 36, depth 2^BUF_SIZE. Port A: fill/engine read-write. Port B: output read.
- Optional: the output prefetch register as a small internal always block; no separate module.

## Test plan
- 10-word packet, header 0x1000000A; engine echoes immediately with access_done -> 10 words out identical, SOF on word 0, EOF on word 9; access_len=10.
- 10-word packet; engine writes header 0x1C000007 at address 0 -> 7 words out, EOF forced on word 6, stored flags elsewhere preserved.
- Packet with access_skip_read=1 at done -> no output; next packet accepted normally with fill_adr from 0.
- 600-word packet with BUF_SIZE=9 -> access_ok never asserted, all 600 words consumed; a following 4-word packet passes through intact.
- dst_rdy_i toggled 1,0,0,1 throughout SEND -> no word lost or duplicated; data_o is stable while stalled.
- Reset asserted mid-FILL at word 5 and again mid-SEND -> next cycle src_rdy_o=0, access_ok=0, dst_rdy_o=1; next packet is output correctly.
